fetch_unit: RTL

//   Instruction-fetch stage; directly feeds the IF/ID pipeline register.
//   - Owns the PC and issues in-order word requests to instruction memory over a valid/ready handshake.
//   - Buffers returned instructions in a small FIFO and presents {pc, instruction, valid} to IF/ID.
//   - Handles stalls from the hazard unit and PC redirects (taken branch/jump) from EX/MEM.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared pipeline definitions: datapath width, NOP encoding and
//            the instruction-fetch FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int          c_XLEN = 32;
  localparam logic [31:0] c_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous instruction buffer with push, pop, clear and an
//            occupancy count; the head word is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int               DEPTH      = 4,
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  // Storage and pointers; clear wins over push/pop, pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_DATA;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, issues in-order word
//            requests to instruction memory, buffers responses and presents
//            {pc, instruction, valid} to IF/ID. Handles stalls and redirects.
// Options  : FETCH_PERF_EN adds perf_fetched / perf_stall_cycles counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [c_XLEN-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [c_XLEN-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [c_XLEN-1:0] imem_rsp_data,
  output logic              fetch_valid,
  output logic [c_XLEN-1:0] fetch_pc,
  output logic [c_XLEN-1:0] fetch_instruction
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [c_XLEN-1:0] r_issue_pc;
  logic [c_XLEN-1:0] r_head_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_discard_cnt;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_credit_used;
  logic [CW-1:0]     w_inflight_left;
  logic [c_XLEN-1:0] w_redirect_target;
  logic              w_req_fire;
  logic              w_rsp_fetch;
  logic              w_push;
  logic              w_pop;
  logic              w_unused_bits;

  assign w_req_fire        = imem_req_valid & imem_req_ready;
  assign w_rsp_fetch       = (r_state == ST_FETCH) & imem_rsp_valid;
  assign w_push            = w_rsp_fetch & ~redirect_valid;
  assign w_pop             = fetch_valid & ~stall & ~redirect_valid;
  assign w_credit_used     = {1'b0, r_outstanding} + {1'b0, w_count};
  // Requests still owed by memory once this cycle's response is accounted for
  assign w_inflight_left   = r_outstanding - {{(CW-1){1'b0}}, w_rsp_fetch};
  assign w_redirect_target = {redirect_pc[c_XLEN-1:2], 2'b00};
  assign w_unused_bits     = &{1'b0, redirect_pc[1:0]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_BOOT;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and request issue; a redirect suppresses issue this cycle
  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req_valid = ~redirect_valid &
                         (w_credit_used < (CW+1)'(FIFO_DEPTH));
        if (redirect_valid && (w_inflight_left != '0)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_discard_cnt == '0) ||
            (imem_rsp_valid && (r_discard_cnt == CW'(1))))
          w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Issue and head PCs; redirect restarts both at the aligned target
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_issue_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      r_issue_pc <= w_redirect_target;
      r_head_pc  <= w_redirect_target;
    end else begin
      if (w_req_fire) r_issue_pc <= r_issue_pc + 32'd4;
      if (w_pop)      r_head_pc  <= r_head_pc + 32'd4;
    end
  end

  // In-flight and discard bookkeeping; a redirect hands in-flight work to discard
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        r_outstanding <= '0;
      end else begin
        case ({w_req_fire, w_rsp_fetch})
          2'b10:   r_outstanding <= r_outstanding + CW'(1);
          2'b01:   r_outstanding <= r_outstanding - CW'(1);
          default: r_outstanding <= r_outstanding;
        endcase
      end
      if (redirect_valid && (r_state == ST_FETCH))
        r_discard_cnt <= w_inflight_left;
      else if ((r_state == ST_DRAIN) && imem_rsp_valid && (r_discard_cnt != '0))
        r_discard_cnt <= r_discard_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .WIDTH      (c_XLEN),
    .RESET_DATA (c_NOP)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (imem_rsp_data),
    .i_pop       (w_pop),
    .o_head      (fetch_instruction),
    .o_count     (w_count)
  );

  assign imem_req_addr = r_issue_pc;
  assign fetch_valid   = (w_count != '0);
  assign fetch_pc      = r_head_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall_cycles;

  // Delivered-instruction and stalled-cycle counters, untouched by redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetched      <= '0;
      r_perf_stall_cycles <= '0;
    end else begin
      if (w_pop)               r_perf_fetched      <= r_perf_fetched + 32'd1;
      if (fetch_valid & stall) r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule
`default_nettype wire
